dds_sweep_ctrl: RTL and testbench

Frequency-sweep scheduler that drives the 24-bit frequency-control word of the DDS phase-accumulator core. It latches a sweep configuration on a start pulse and steps the word from a start value toward a stop value, holding each value for a programmable number of clocks. It supports single-shot, sawtooth-repeat and triangle modes. It sits between the control/register logic and the DDS `fre` (or `fre2`) input, in the same 100 MHz domain.

---
 rtl/dds_ctrl_pkg.sv | 17 +
 rtl/dds_dwell_timer.sv | 29 ++
 rtl/dds_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_ctrl_pkg.sv
// Shared constants and types for the DDS frequency-sweep controller.
package dds_ctrl_pkg;

    localparam int FW = 24;
    localparam int DW = 24;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; a load value of 0 behaves like 1 so every word
// is held for at least one clock.
module dds_dwell_timer
    import dds_ctrl_pkg::*;
#(
    parameter int DW = dds_ctrl_pkg::DW
) (
    input  logic          clk_100M,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] dwell,
    output logic          zero
);

    logic [DW-1:0] cnt_reg;

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= (dwell == '0) ? '0 : dwell - DW'(1);
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - DW'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS phase accumulator: steps the frequency
// word from start toward stop in single, sawtooth or triangle mode.
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int FW = dds_ctrl_pkg::FW,
    parameter int DW = dds_ctrl_pkg::DW
) (
    input  logic          clk_100M,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [FW-1:0] start_fre,
    input  logic [FW-1:0] stop_fre,
    input  logic [FW-1:0] step_fre,
    input  logic [DW-1:0] dwell,
    output logic [FW-1:0] fre,
    output logic          busy,
    output logic          dir_down,
    output logic          done
);

    sweep_state_t  state_reg;
    logic [FW-1:0] fre_reg;
    logic          busy_reg;
    logic          dir_reg;
    logic          done_reg;
    logic [FW-1:0] cfg_start_reg;
    logic [FW-1:0] cfg_stop_reg;
    logic [FW-1:0] cfg_step_reg;
    logic [1:0]    cfg_mode_reg;
    logic [DW-1:0] cfg_dwell_reg;

    logic          degenerate;
    logic          at_stop;
    logic          is_single;
    logic          timer_load;
    logic [DW-1:0] timer_val;
    logic          dwell_zero;
    logic [FW-1:0] step_next;
    logic [FW-1:0] turn_next;

    // One step toward a target, saturating at the target; the extra bit
    // catches carry/borrow so the word can never wrap past it.
    function automatic logic [FW-1:0] step_toward(
        input logic [FW-1:0] cur,
        input logic [FW-1:0] step,
        input logic [FW-1:0] target,
        input logic          down
    );
        logic [FW:0] r;
        if (down) begin
            r = {1'b0, cur} - {1'b0, step};
            if (r[FW] || (r[FW-1:0] <= target)) r = {1'b0, target};
        end else begin
            r = {1'b0, cur} + {1'b0, step};
            if (r[FW] || (r[FW-1:0] >= target)) r = {1'b0, target};
        end
        return r[FW-1:0];
    endfunction

    assign degenerate = (step_fre == '0) || (start_fre == stop_fre);
    assign at_stop    = (fre_reg == cfg_stop_reg);
    assign is_single  = (cfg_mode_reg != MODE_SAW) && (cfg_mode_reg != MODE_TRI);
    assign step_next  = step_toward(fre_reg, cfg_step_reg, cfg_stop_reg, dir_reg);
    assign turn_next  = step_toward(fre_reg, cfg_step_reg, cfg_start_reg, !dir_reg);

    assign timer_load = !abort &&
                        (((state_reg == IDLE) && start && !degenerate) ||
                         (state_reg == STEP));
    assign timer_val  = (state_reg == IDLE) ? dwell : cfg_dwell_reg;

    dds_dwell_timer #(.DW(DW)) u_dwell_timer (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .load     (timer_load),
        .dwell    (timer_val),
        .zero     (dwell_zero)
    );

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            fre_reg       <= '0;
            busy_reg      <= 1'b0;
            dir_reg       <= 1'b0;
            done_reg      <= 1'b0;
            cfg_start_reg <= '0;
            cfg_stop_reg  <= '0;
            cfg_step_reg  <= '0;
            cfg_mode_reg  <= MODE_SINGLE;
            cfg_dwell_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            cfg_start_reg <= start_fre;
                            cfg_stop_reg  <= stop_fre;
                            cfg_step_reg  <= step_fre;
                            cfg_mode_reg  <= mode;
                            cfg_dwell_reg <= dwell;
                            fre_reg       <= start_fre;
                            dir_reg       <= (start_fre > stop_fre);
                            if (degenerate) begin
                                done_reg <= 1'b1;
                            end else begin
                                state_reg <= DWELL;
                                busy_reg  <= 1'b1;
                            end
                        end
                    end
                    DWELL: begin
                        if (dwell_zero) begin
                            // A finished single sweep ends in the slot STEP
                            // would occupy, so done and !busy line up there.
                            if (at_stop && is_single) begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= STEP;
                            end
                        end
                    end
                    STEP: begin
                        state_reg <= DWELL;
                        if (!at_stop) begin
                            fre_reg <= step_next;
                        end else begin
                            case (cfg_mode_reg)
                                MODE_SAW: fre_reg <= cfg_start_reg;
                                MODE_TRI: begin
                                    cfg_start_reg <= cfg_stop_reg;
                                    cfg_stop_reg  <= cfg_start_reg;
                                    dir_reg       <= !dir_reg;
                                    fre_reg       <= turn_next;
                                end
                                default: begin
                                    state_reg <= IDLE;
                                    busy_reg  <= 1'b0;
                                    done_reg  <= 1'b1;
                                end
                            endcase
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign fre      = fre_reg;
    assign busy     = busy_reg;
    assign dir_down = dir_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl.
module tb_dds_sweep_ctrl;

    logic        clk_100M;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [23:0] start_fre;
    logic [23:0] stop_fre;
    logic [23:0] step_fre;
    logic [23:0] dwell;
    logic [23:0] fre;
    logic        busy;
    logic        dir_down;
    logic        done;

    int pass_cnt;
    int total_cnt;

    logic [26:0] obs;
    logic [26:0] exp_v;

    dds_sweep_ctrl dut (
        .clk_100M  (clk_100M),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .start_fre (start_fre),
        .stop_fre  (stop_fre),
        .step_fre  (step_fre),
        .dwell     (dwell),
        .fre       (fre),
        .busy      (busy),
        .dir_down  (dir_down),
        .done      (done)
    );

    initial clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    assign obs = {fre, busy, done, dir_down};

    task automatic cyc();
        @(posedge clk_100M);
        #1;
    endtask

    // Pulse start for one edge; on return the bench sits in cycle 1 after it.
    task automatic kick(input logic [1:0] m, input logic [23:0] s, input logic [23:0] e,
                        input logic [23:0] st, input logic [23:0] dw);
        mode = m; start_fre = s; stop_fre = e; step_fre = st; dwell = dw;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
        start_fre = '0; stop_fre = '0; step_fre = '0; dwell = '0;
        cyc(); cyc();
        total_cnt++;
        if (obs !== 27'd0) $display("FAIL reset_hold got fre=%0h b/d/dir=%b want 0", fre, obs[2:0]);
        else pass_cnt++;
        rst_n = 1'b1;
        cyc(); cyc();
        total_cnt++;
        if (obs !== 27'd0) $display("FAIL reset_release got fre=%0h b/d/dir=%b want 0", fre, obs[2:0]);
        else pass_cnt++;
        $display("test_reset: checked");
    endtask

    task automatic test_up_single();
        logic [23:0] vals [4] = '{24'd100, 24'd110, 24'd120, 24'd130};
        kick(2'd0, 24'd100, 24'd130, 24'd10, 24'd2);
        for (int k = 1; k <= 14; k++) begin
            int idx;
            idx = (k - 1) / 3;
            if (idx > 3) idx = 3;
            exp_v = {vals[idx], (k < 12) ? 1'b1 : 1'b0, (k == 12) ? 1'b1 : 1'b0, 1'b0};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL up_single k=%0d got fre=%0d b/d/dir=%b want fre=%0d b/d/dir=%b",
                                        k, fre, obs[2:0], exp_v[26:3], exp_v[2:0]);
            else pass_cnt++;
            // start with a new config while busy must be ignored
            start = (k == 4);
            if (k == 4) start_fre = 24'd999;
            cyc();
        end
        start = 1'b0;
        $display("test_up_single: checked");
    endtask

    task automatic test_clamp_up();
        logic [23:0] vals [2] = '{24'hFFFFF0, 24'hFFFFFF};
        kick(2'd0, 24'hFFFFF0, 24'hFFFFFF, 24'h20, 24'd1);
        for (int k = 1; k <= 5; k++) begin
            int idx;
            idx = (k - 1) / 2;
            if (idx > 1) idx = 1;
            exp_v = {vals[idx], (k < 4) ? 1'b1 : 1'b0, (k == 4) ? 1'b1 : 1'b0, 1'b0};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL clamp_up k=%0d got fre=%0h b/d/dir=%b want fre=%0h b/d/dir=%b",
                                        k, fre, obs[2:0], exp_v[26:3], exp_v[2:0]);
            else pass_cnt++;
            cyc();
        end
        $display("test_clamp_up: checked");
    endtask

    task automatic test_clamp_down();
        logic [23:0] vals [4] = '{24'd50, 24'd30, 24'd10, 24'd5};
        kick(2'd0, 24'd50, 24'd5, 24'd20, 24'd0);
        for (int k = 1; k <= 9; k++) begin
            int idx;
            idx = (k - 1) / 2;
            if (idx > 3) idx = 3;
            exp_v = {vals[idx], (k < 8) ? 1'b1 : 1'b0, (k == 8) ? 1'b1 : 1'b0, 1'b1};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL clamp_down k=%0d got fre=%0d b/d/dir=%b want fre=%0d b/d/dir=%b",
                                        k, fre, obs[2:0], exp_v[26:3], exp_v[2:0]);
            else pass_cnt++;
            cyc();
        end
        $display("test_clamp_down: checked");
    endtask

    task automatic test_triangle();
        logic [23:0] tri_vals [4] = '{24'd0, 24'd2, 24'd4, 24'd2};
        kick(2'd2, 24'd0, 24'd4, 24'd2, 24'd1);
        for (int k = 1; k <= 16; k++) begin
            int g;
            logic exp_dir;
            g = (k - 1) / 2;
            exp_dir = ((g % 4) == 3) || (((g % 4) == 0) && (g > 0));
            exp_v = {tri_vals[g % 4], 1'b1, 1'b0, exp_dir};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL triangle k=%0d got fre=%0d b/d/dir=%b want fre=%0d b/d/dir=%b",
                                        k, fre, obs[2:0], exp_v[26:3], exp_v[2:0]);
            else pass_cnt++;
            cyc();
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL triangle_abort got busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
        $display("test_triangle: checked");
    endtask

    task automatic test_sawtooth();
        logic [23:0] vals [2] = '{24'd10, 24'd20};
        kick(2'd1, 24'd10, 24'd20, 24'd10, 24'd0);
        for (int k = 1; k <= 8; k++) begin
            exp_v = {vals[((k - 1) / 2) % 2], 1'b1, 1'b0, 1'b0};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL sawtooth k=%0d got fre=%0d b/d/dir=%b want fre=%0d b/d/dir=%b",
                                        k, fre, obs[2:0], exp_v[26:3], exp_v[2:0]);
            else pass_cnt++;
            cyc();
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        $display("test_sawtooth: checked");
    endtask

    task automatic test_abort();
        logic [23:0] vals [3] = '{24'd200, 24'd215, 24'd230};
        kick(2'd0, 24'd100, 24'd130, 24'd10, 24'd2);
        for (int k = 1; k < 5; k++) cyc();
        total_cnt++;
        if (fre !== 24'd110 || busy !== 1'b1) $display("FAIL abort_pre got fre=%0d busy=%b want 110 1", fre, busy);
        else pass_cnt++;
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_v = {24'd110, 1'b0, 1'b0, 1'b0};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL abort_hold n=%0d got fre=%0d b/d/dir=%b want fre=110 b/d/dir=000",
                                        k, fre, obs[2:0]);
            else pass_cnt++;
            cyc();
        end
        kick(2'd0, 24'd200, 24'd230, 24'd15, 24'd1);
        for (int k = 1; k <= 7; k++) begin
            int idx;
            idx = (k - 1) / 2;
            if (idx > 2) idx = 2;
            exp_v = {vals[idx], (k < 6) ? 1'b1 : 1'b0, (k == 6) ? 1'b1 : 1'b0, 1'b0};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL abort_restart k=%0d got fre=%0d b/d/dir=%b want fre=%0d b/d/dir=%b",
                                        k, fre, obs[2:0], exp_v[26:3], exp_v[2:0]);
            else pass_cnt++;
            cyc();
        end
        $display("test_abort: checked");
    endtask

    task automatic test_degenerate();
        kick(2'd0, 24'd77, 24'd90, 24'd0, 24'd3);
        exp_v = {24'd77, 1'b0, 1'b1, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL degen_step0 got fre=%0d b/d/dir=%b want fre=77 b/d/dir=010", fre, obs[2:0]);
        else pass_cnt++;
        cyc();
        exp_v = {24'd77, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL degen_step0_after got fre=%0d b/d/dir=%b want fre=77 b/d/dir=000", fre, obs[2:0]);
        else pass_cnt++;
        kick(2'd1, 24'd55, 24'd55, 24'd5, 24'd3);
        exp_v = {24'd55, 1'b0, 1'b1, 1'b0};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL degen_equal got fre=%0d b/d/dir=%b want fre=55 b/d/dir=010", fre, obs[2:0]);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL degen_equal_after got busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
        $display("test_degenerate: checked");
    endtask

    task automatic test_async_reset();
        kick(2'd0, 24'd50, 24'd5, 24'd20, 24'd0);
        cyc(); cyc(); cyc();
        total_cnt++;
        if (fre !== 24'd30 || busy !== 1'b1 || dir_down !== 1'b1)
            $display("FAIL rst_pre got fre=%0d busy=%b dir=%b want 30 1 1", fre, busy, dir_down);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (obs !== 27'd0) $display("FAIL rst_async got fre=%0d b/d/dir=%b want 0", fre, obs[2:0]);
        else pass_cnt++;
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        total_cnt++;
        if (obs !== 27'd0) $display("FAIL rst_after got fre=%0d b/d/dir=%b want 0", fre, obs[2:0]);
        else pass_cnt++;
        $display("test_async_reset: checked");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_up_single();
        test_clamp_up();
        test_clamp_down();
        test_triangle();
        test_sawtooth();
        test_abort();
        test_degenerate();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
